// File: rtl/max_tree_seg_acc.sv
// Pipelined signed max-reduction over N lanes with selectable segment size, masking and
// multi-beat running max. Optional argmax output enabled by defining MAX_TREE_ARGMAX_EN.
module max_tree_seg_acc #(
    parameter int N       = 64,
    parameter int DW      = 16,
    parameter int MIN_SEG = 16,
    parameter int LMW     = 2,
    parameter int BEAT_W  = 8
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic                                             i_en,
    input  logic                                             i_valid,
    input  logic                                             i_last,
    input  logic [LMW-1:0]                                   i_length_mode,
    input  logic [N-1:0]                                     i_mask,
    input  logic [N*DW-1:0]                                  i_in_flat,
`ifdef MAX_TREE_ARGMAX_EN
    output logic [(N/MIN_SEG)*($clog2(N)+BEAT_W)-1:0]        o_seg_idx,
`endif
    output logic                                             o_valid,
    output logic [(N/MIN_SEG)*DW-1:0]                        o_seg_max,
    output logic                                             o_byp_valid,
    output logic [N*DW-1:0]                                  o_in_byp,
    output logic [N-1:0]                                     o_mask_byp,
    output logic [LMW-1:0]                                   o_length_mode_byp,
    output logic                                             o_last_byp
);

    localparam int NSEG    = N / MIN_SEG;
    localparam int LOGN    = $clog2(N);
    localparam int LOGNSEG = $clog2(NSEG);
    localparam int SEG_LVL = LOGN - LOGNSEG;
`ifdef MAX_TREE_ARGMAX_EN
    localparam int IW      = LOGN + BEAT_W;
`endif
    localparam logic signed [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} row_state_t;

    function automatic logic [LMW-1:0] clamp_mode(input logic [LMW-1:0] m);
        if (int'(m) > LOGNSEG) return LMW'(LOGNSEG);
        return m;
    endfunction

    // Tie goes to the lower-index operand.
    function automatic logic keep_lo(input logic signed [DW-1:0] lo, input logic signed [DW-1:0] hi);
        return lo >= hi;
    endfunction

    if (BEAT_W < 1 || N < MIN_SEG) begin : g_unsupported_params
    end

    // Row tracker on the input side: the row's first beat fixes the mode for the whole row,
    // so the tree can stop merging at the right level before the accumulator sees the beat.
    logic           accept;
    logic           in_row_q;
    logic [LMW-1:0] row_mode_q;
    logic [LMW-1:0] eff_mode;

    assign accept   = i_en & i_valid;
    assign eff_mode = in_row_q ? row_mode_q : clamp_mode(i_length_mode);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            in_row_q   <= 1'b0;
            row_mode_q <= '0;
        end else if (accept) begin
            in_row_q   <= ~i_last;
            row_mode_q <= eff_mode;
        end
    end

    logic            vld_p  [1:LOGN];
    logic            last_p [1:LOGN];
    logic [LMW-1:0]  mode_p [1:LOGN];
    logic [N*DW-1:0] in_p   [1:LOGN];
    logic [N-1:0]    mask_p [1:LOGN];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 1; s <= LOGN; s++) begin
                vld_p[s]  <= 1'b0;
                last_p[s] <= 1'b0;
                mode_p[s] <= '0;
            end
        end else if (i_en) begin
            vld_p[1]  <= i_valid;
            last_p[1] <= i_last;
            mode_p[1] <= eff_mode;
            for (int s = 2; s <= LOGN; s++) begin
                vld_p[s]  <= vld_p[s-1];
                last_p[s] <= last_p[s-1];
                mode_p[s] <= mode_p[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            in_p[1]   <= i_in_flat;
            mask_p[1] <= i_mask;
            for (int s = 2; s <= LOGN; s++) begin
                in_p[s]   <= in_p[s-1];
                mask_p[s] <= mask_p[s-1];
            end
        end
    end

    // Stages 1..SEG_LVL: plain pairwise reduction down to one value per MIN_SEG block.
    genvar s, k, t;
    for (s = 0; s <= SEG_LVL; s++) begin : g_red
        localparam int W = N >> s;
        logic signed [DW-1:0] val [W];
`ifdef MAX_TREE_ARGMAX_EN
        logic [LOGN-1:0]      pos [W];
`endif
        if (s == 0) begin : g_leaf
            for (k = 0; k < W; k++) begin : g_el
                assign val[k] = i_mask[k] ? $signed(i_in_flat[k*DW +: DW]) : NEG_MAX;
`ifdef MAX_TREE_ARGMAX_EN
                assign pos[k] = LOGN'(k);
`endif
            end
        end else begin : g_node
            always_ff @(posedge i_clk) begin
                if (i_en) begin
                    for (int e = 0; e < W; e++) begin
                        if (keep_lo(g_red[s-1].val[2*e], g_red[s-1].val[2*e+1])) begin
                            val[e] <= g_red[s-1].val[2*e];
`ifdef MAX_TREE_ARGMAX_EN
                            pos[e] <= g_red[s-1].pos[2*e];
`endif
                        end else begin
                            val[e] <= g_red[s-1].val[2*e+1];
`ifdef MAX_TREE_ARGMAX_EN
                            pos[e] <= g_red[s-1].pos[2*e+1];
`endif
                        end
                    end
                end
            end
        end
    end

    // Remaining stages: butterfly across the NSEG lanes so each lane already holds its
    // segment's max; merging stops once the row's segment size is reached.
    for (t = 1; t <= LOGNSEG; t++) begin : g_bfy
        localparam int D  = 1 << (t - 1);
        localparam int ST = SEG_LVL + t;
        logic signed [DW-1:0] src [NSEG];
        logic signed [DW-1:0] val [NSEG];
`ifdef MAX_TREE_ARGMAX_EN
        logic [LOGN-1:0]      src_pos [NSEG];
        logic [LOGN-1:0]      pos     [NSEG];
`endif
        for (k = 0; k < NSEG; k++) begin : g_src
            if (t == 1) begin : g_first
                assign src[k] = g_red[SEG_LVL].val[k];
`ifdef MAX_TREE_ARGMAX_EN
                assign src_pos[k] = g_red[SEG_LVL].pos[k];
`endif
            end else begin : g_next
                assign src[k] = g_bfy[t-1].val[k];
`ifdef MAX_TREE_ARGMAX_EN
                assign src_pos[k] = g_bfy[t-1].pos[k];
`endif
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_en) begin
                for (int j = 0; j < NSEG; j++) begin
                    if (t > LOGNSEG - int'(mode_p[ST-1])) begin
                        val[j] <= src[j];
`ifdef MAX_TREE_ARGMAX_EN
                        pos[j] <= src_pos[j];
`endif
                    end else if (keep_lo(src[j & ~D], src[j | D])) begin
                        val[j] <= src[j & ~D];
`ifdef MAX_TREE_ARGMAX_EN
                        pos[j] <= src_pos[j & ~D];
`endif
                    end else begin
                        val[j] <= src[j | D];
`ifdef MAX_TREE_ARGMAX_EN
                        pos[j] <= src_pos[j | D];
`endif
                    end
                end
            end
        end
    end

    logic signed [DW-1:0] tree_v [NSEG];
`ifdef MAX_TREE_ARGMAX_EN
    logic [LOGN-1:0]      tree_pos [NSEG];
`endif
    for (k = 0; k < NSEG; k++) begin : g_tree_out
        if (LOGNSEG == 0) begin : g_red_only
            assign tree_v[k] = g_red[SEG_LVL].val[k];
`ifdef MAX_TREE_ARGMAX_EN
            assign tree_pos[k] = g_red[SEG_LVL].pos[k];
`endif
        end else begin : g_bfy_last
            assign tree_v[k] = g_bfy[LOGNSEG].val[k];
`ifdef MAX_TREE_ARGMAX_EN
            assign tree_pos[k] = g_bfy[LOGNSEG].pos[k];
`endif
        end
    end

    // Accumulation stage: row FSM, running max and publication.
    row_state_t           state_q, state_d;
    logic                 pub_d;
    logic signed [DW-1:0] acc_q [NSEG];
    logic signed [DW-1:0] acc_d [NSEG];
    logic signed [DW-1:0] seg_q [NSEG];
    logic signed [DW-1:0] seg_d [NSEG];
    logic signed [DW-1:0] mrg   [NSEG];
`ifdef MAX_TREE_ARGMAX_EN
    logic [BEAT_W-1:0]    beat_q, beat_d, beat_cur;
    logic [IW-1:0]        aidx_q [NSEG];
    logic [IW-1:0]        aidx_d [NSEG];
    logic [IW-1:0]        sidx_q [NSEG];
    logic [IW-1:0]        sidx_d [NSEG];
    logic [IW-1:0]        midx   [NSEG];
`endif

    always_comb begin
        state_d = state_q;
        pub_d   = 1'b0;
`ifdef MAX_TREE_ARGMAX_EN
        beat_cur = (state_q == IDLE) ? '0 : beat_q;
        beat_d   = beat_q;
`endif
        for (int j = 0; j < NSEG; j++) begin
            acc_d[j] = acc_q[j];
            seg_d[j] = seg_q[j];
            mrg[j]   = (tree_v[j] > acc_q[j]) ? tree_v[j] : acc_q[j];
`ifdef MAX_TREE_ARGMAX_EN
            aidx_d[j] = aidx_q[j];
            sidx_d[j] = sidx_q[j];
            midx[j]   = (tree_v[j] > acc_q[j]) ? {beat_cur, tree_pos[j]} : aidx_q[j];
`endif
        end
        if (vld_p[LOGN]) begin
            for (int j = 0; j < NSEG; j++) begin
                acc_d[j] = (state_q == IDLE) ? tree_v[j] : mrg[j];
`ifdef MAX_TREE_ARGMAX_EN
                aidx_d[j] = (state_q == IDLE) ? {beat_cur, tree_pos[j]} : midx[j];
`endif
            end
            if (last_p[LOGN]) begin
                pub_d   = 1'b1;
                state_d = IDLE;
                for (int j = 0; j < NSEG; j++) begin
                    seg_d[j] = acc_d[j];
`ifdef MAX_TREE_ARGMAX_EN
                    sidx_d[j] = aidx_d[j];
`endif
                end
`ifdef MAX_TREE_ARGMAX_EN
                beat_d = '0;
`endif
            end else begin
                state_d = ACCUM;
`ifdef MAX_TREE_ARGMAX_EN
                beat_d = (beat_cur == {BEAT_W{1'b1}}) ? beat_cur : beat_cur + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            o_valid <= 1'b0;
            for (int j = 0; j < NSEG; j++) begin
                acc_q[j] <= '0;
                seg_q[j] <= '0;
`ifdef MAX_TREE_ARGMAX_EN
                aidx_q[j] <= '0;
                sidx_q[j] <= '0;
`endif
            end
`ifdef MAX_TREE_ARGMAX_EN
            beat_q <= '0;
`endif
        end else if (i_en) begin
            state_q <= state_d;
            o_valid <= pub_d;
            for (int j = 0; j < NSEG; j++) begin
                acc_q[j] <= acc_d[j];
                seg_q[j] <= seg_d[j];
`ifdef MAX_TREE_ARGMAX_EN
                aidx_q[j] <= aidx_d[j];
                sidx_q[j] <= sidx_d[j];
`endif
            end
`ifdef MAX_TREE_ARGMAX_EN
            beat_q <= beat_d;
`endif
        end
    end

    for (k = 0; k < NSEG; k++) begin : g_out
        assign o_seg_max[k*DW +: DW] = seg_q[k];
`ifdef MAX_TREE_ARGMAX_EN
        assign o_seg_idx[k*IW +: IW] = sidx_q[k];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_byp_valid       <= 1'b0;
            o_last_byp        <= 1'b0;
            o_in_byp          <= '0;
            o_mask_byp        <= '0;
            o_length_mode_byp <= '0;
        end else if (i_en) begin
            o_byp_valid       <= vld_p[LOGN];
            o_last_byp        <= last_p[LOGN];
            o_in_byp          <= in_p[LOGN];
            o_mask_byp        <= mask_p[LOGN];
            o_length_mode_byp <= mode_p[LOGN];
        end
    end

endmodule

// File: doc/max_tree_seg_acc.md
Name: max_tree_seg_acc

Overview:
- Parametrised successor to the fixed 64-lane max tree.
- Pipelined signed max-reduction over N lanes, with a selectable segment size and per-element masking.
- Accumulates a running max across multiple beats, so rows longer than N are supported.
- Sits ahead of the softmax subtract-max/exp stage; raw inputs are bypassed, latency-aligned, for that stage.

Parameters:
N, 64, lanes per beat; power of 2, >= MIN_SEG
DW, 16, element width, signed fixed point
MIN_SEG, 16, smallest segment size; NSEG = N/MIN_SEG output lanes
LMW, 2, width of i_length_mode; must satisfy 2^LMW > log2(NSEG)
BEAT_W, 8, beat-counter width (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_en  in  1  global advance; 0 freezes every register
i_valid  in  1  input beat valid
i_last  in  1  beat closes the current row
i_length_mode  in  LMW  segment size = N>>mode; values above log2(NSEG) clamp to log2(NSEG)
i_mask  in  N  per-element valid; 0 forces element to -2^(DW-1)
i_in_flat  in  N*DW  element k at [k*DW +: DW]
o_valid  out  1  row result valid (one cycle per row)
o_seg_max  out  NSEG*DW  lane j = max of segment containing element j*MIN_SEG
o_byp_valid  out  1  per-beat bypass valid
o_in_byp  out  N*DW  i_in_flat delayed by L
o_mask_byp  out  N  i_mask delayed by L
o_length_mode_byp  out  LMW  effective (row-latched) mode delayed by L
o_last_byp  out  1  i_last delayed by L

Behaviour:
- Tree: log2(N) registered pairwise stages, signed compare. On a tie the lower-index operand wins.
- Segment outputs are taken at tree level log2(N>>mode). Each segment max is broadcast to every lane j inside that segment (mode 0: all NSEG lanes equal).
- Accumulation stage (1 register level) gives total latency L = log2(N)+1, i.e. 7 for N=64, from accepted beat to o_valid / o_byp_valid.
- Accept condition: i_en & i_valid. Every stage carries a valid bit. Bubbles propagate with valid=0; bypass regs still shift.
- Row FSM, evaluated at accumulation stage on a valid beat:
  - IDLE: acc <= tree result; mode latched from this beat. If last, o_seg_max <= result, o_valid <= 1, stay IDLE; else -> ACCUM.
  - ACCUM: acc[j] <= max(acc[j], tree[j]); strictly greater replaces. If last, publish max(acc, tree), o_valid <= 1, -> IDLE; else stay ACCUM.
- Mode is sampled only on the row's first beat (the beat accepted in IDLE). Later beats' i_length_mode is ignored, and o_length_mode_byp reports the latched mode.
- o_valid pulses one cycle only when i_en=1; with i_en=0 it holds its value.
- Beats with valid=0 do not change acc or the FSM.
- o_seg_max holds its last published value until the next row completes.
- All-masked segment yields -2^(DW-1).
- Reset (i_rst_n=0 at a rising edge):
  - All stage valids, o_valid, o_byp_valid, o_last_byp, FSM (-> IDLE) and acc clear to 0.
  - o_seg_max, o_in_byp, o_mask_byp, o_length_mode_byp reset to 0.
  - Reset dominates i_en. A row in flight is discarded; the next accepted beat starts a fresh row.
- i_en=0: no state changes anywhere, including the FSM, and inputs are not accepted.

Optional Feature:
- Macro MAX_TREE_ARGMAX_EN.
- Defined: adds output o_seg_idx [NSEG*(log2(N)+BEAT_W)].
  - Per lane: index of the winning element = beat_number*N + element position (absolute element index in row).
  - Beat counter resets in IDLE and saturates at 2^BEAT_W-1.
  - Ties: earliest beat, then lowest element, wins.
  - Reset value 0; published with o_valid.
- Undefined: no port, no index logic, no beat counter.

Test Plan:
1. N=64, mode0, last=1, data[k]=k, data[0]=500, all mask 1 -> after 7 cycles o_valid=1 for one cycle; o_seg_max lanes 0..3 = 500; o_byp_valid same cycle with o_in_byp = input.
2. mode1, data[k]=k -> lanes 0,1 = 31, lanes 2,3 = 63; mode2, data[k]=-100+k -> lanes = -85, -69, -53, -37; mode3 (clamped) behaves as mode2.
3. mode0, all data 10, data[63]=999 with mask[63]=0 -> all lanes 10; mask all 0 -> all lanes -32768.
4. Three-beat row, mode0, beat maxes 5/700/20, beat2 mode=2, last on beat3:
   - No o_valid after beats 1 and 2.
   - o_valid 7 cycles after beat3, all lanes 700; o_length_mode_byp = 0 on all three bypass beats.
   - o_byp_valid pulses three times.
5. i_en low for 3 cycles while a beat is in stage 3 -> o_valid arrives exactly 3 cycles late, same value; no duplicate pulse.
6. Reset asserted after beat1 of a 2-beat row, then a single-beat row with max 42 -> o_valid 7 cycles after that beat, lanes = 42, no stale value from beat1. With MAX_TREE_ARGMAX_EN, test 1 additionally gives o_seg_idx lanes = 0.
